// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and defaults for the CDC handshake transmit/receive ends.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdc_pkg;

   // Handshake phases of the transmit end.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } state_e;

   localparam int CDC_DATA_WIDTH_DEF = 8;
   localparam int CDC_NUM_STAGES_DEF = 2;

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: plain multi-flop level synchronizer, async active-high reset to 0.
// Latency: NUM_STAGES clk edges from d to q.
// Backpressure: none; level signals only.
// Ports: clk, rst, d (asynchronous level in), q (synchronized level out).
module sync_ff_chain #(
   parameter int NUM_STAGES = 2,
   parameter int WIDTH      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [NUM_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [NUM_STAGES-1:0][WIDTH-1:0] sync_d;

   // The asynchronous input lands directly on the first flop; no gating in front of it.
   always_comb begin
      sync_d = {sync_q[NUM_STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: launching-domain end of a 4-phase req/ack CDC handshake.
// Latency: REQ 1 edge after accept; REQ falls / READY returns NUM_STAGES+1 edges after ACK_ASYNC edges.
// Backpressure: READY low while a word is in flight (CDC_TX_SKID_EN: low only while the skid entry is full).
// Ports: CLK, RST (async active-high); DATA_IN/DATA_VALID/READY intake; DATA_OUT/REQ to the
//   destination; ACK_ASYNC from the destination; TX_DONE one-cycle pulse per acknowledged word.
module cdc_handshake_tx
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH = CDC_DATA_WIDTH_DEF,
   parameter int NUM_STAGES = CDC_NUM_STAGES_DEF
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  DATA_VALID,
   output logic                  READY,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  REQ,
   input  logic                  ACK_ASYNC,
   output logic                  TX_DONE
);

   logic ack_s;

   sync_ff_chain #(
      .NUM_STAGES (NUM_STAGES),
      .WIDTH      (1)
   ) u_ack_sync (
      .clk (CLK),
      .rst (RST),
      .d   (ACK_ASYNC),
      .q   (ack_s)
   );

   state_e                state_q, state_d;
   logic                  req_q, req_d;
   logic                  ready_q, ready_d;
   logic                  tx_done_q, tx_done_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  accept;

   assign accept = DATA_VALID && ready_q;

`ifdef CDC_TX_SKID_EN
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  buf_full_q, buf_full_d;
   logic                  drain, direct, store;

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      tx_done_d  = 1'b0;
      data_out_d = data_out_q;
      buf_d      = buf_q;
      drain      = 1'b0;
      direct     = 1'b0;
      case (state_q)
         // A buffered word always goes before a new one to keep FIFO order.
         IDLE: begin
            if (!ack_s) begin
               if (buf_full_q)  drain  = 1'b1;
               else if (accept) direct = 1'b1;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d     = 1'b0;
               tx_done_d = 1'b1;
               state_d   = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s) begin
               if (buf_full_q) drain   = 1'b1;
               else            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (drain || direct) begin
         data_out_d = drain ? buf_q : DATA_IN;
         req_d      = 1'b1;
         state_d    = REQ_HI;
      end
      // Any accepted word not launched directly parks in the buffer, including on a drain edge.
      store = accept && !direct;
      if (store) buf_d = DATA_IN;
      buf_full_d = (buf_full_q && !drain) || store;
      ready_d    = !buf_full_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
      end
   end
`else
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      ready_d    = ready_q;
      tx_done_d  = 1'b0;
      data_out_d = data_out_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_out_d = DATA_IN;
               req_d      = 1'b1;
               ready_d    = 1'b0;
               state_d    = REQ_HI;
            end else begin
               // A stale ack from the previous exchange blocks new words until it clears.
               ready_d = !ack_s;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d     = 1'b0;
               tx_done_d = 1'b1;
               state_d   = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s) begin
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         ready_q    <= 1'b0;
         tx_done_q  <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         ready_q    <= ready_d;
         tx_done_q  <= tx_done_d;
         data_out_q <= data_out_d;
      end
   end

   assign READY    = ready_q;
   assign REQ      = req_q;
   assign TX_DONE  = tx_done_q;
   assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed + randomized checks of cdc_handshake_tx.
// The destination is modelled as an ack that echoes REQ three cycles later.
// Build with CDC_TX_SKID_EN defined to exercise the skid-buffer variant.
module tb_cdc_handshake_tx;

   localparam int DW  = 8;
   localparam int NS  = 2;
   localparam int LAT = NS + 1;
`ifdef CDC_TX_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST;
   logic [DW-1:0] DATA_IN;
   logic          DATA_VALID;
   logic          READY;
   logic [DW-1:0] DATA_OUT;
   logic          REQ;
   logic          ACK_ASYNC;
   logic          TX_DONE;

   int            n_assert = 0;
   int            n_fail   = 0;
   int            done_cnt = 0;
   logic [2:0]    req_sh;
   bit            ack_auto;
   logic          ack_man;
   logic [DW-1:0] sent_q[$];

   always #5 CLK = ~CLK;

   cdc_handshake_tx #(
      .DATA_WIDTH (DW),
      .NUM_STAGES (NS)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_IN    (DATA_IN),
      .DATA_VALID (DATA_VALID),
      .READY      (READY),
      .DATA_OUT   (DATA_OUT),
      .REQ        (REQ),
      .ACK_ASYNC  (ACK_ASYNC),
      .TX_DONE    (TX_DONE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample just after the edge, advance the destination model, score TX_DONE.
   task automatic tick();
      logic [31:0] exp_w;
      @(posedge CLK);
      #1;
      req_sh    = {req_sh[1:0], REQ};
      ACK_ASYNC = ack_auto ? req_sh[2] : ack_man;
      if (TX_DONE === 1'b1) begin
         done_cnt++;
         exp_w = (sent_q.size() > 0) ? 32'(sent_q.pop_front()) : 32'hDEAD_BEEF;
         chk("done_word_order", 32'(DATA_OUT), exp_w);
      end
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (READY !== 1'b1 && k < 50) begin
         tick();
         k++;
      end
      chk(tag, 32'(READY), 32'(1));
   endtask

   // Offer one word while READY is high and the block is idle; it must launch on the next edge.
   task automatic launch(input logic [DW-1:0] w);
      DATA_IN    = w;
      DATA_VALID = 1'b1;
      sent_q.push_back(w);
      tick();
      DATA_VALID = 1'b0;
      chk("launch_req", 32'(REQ), 32'(1));
      chk("launch_data", 32'(DATA_OUT), 32'(w));
      chk("launch_ready", 32'(READY), 32'(SKID));
      chk("launch_no_done", 32'(TX_DONE), 32'(0));
   endtask

   // Follow one word from launch to completion, checking every cycle against the timing rules:
   // REQ falls with a TX_DONE pulse LAT edges after ACK rises, READY returns LAT edges after ACK falls.
   task automatic handshake(input logic [DW-1:0] w, input bit hold, input logic [DW-1:0] nxt);
      int   rise_at = -1;
      int   fall_at = -1;
      int   t       = 0;
      bit   fin     = 1'b0;
      logic exp_req, exp_done, exp_ready;
      if (hold) begin
         DATA_IN    = nxt;
         DATA_VALID = 1'b1;
      end
      while (!fin && t < 60) begin
         t++;
         tick();
         exp_req   = (rise_at < 0) || (t < rise_at + LAT);
         exp_done  = (rise_at >= 0) && (t == rise_at + LAT);
         exp_ready = SKID ? 1'b1 : ((fall_at >= 0) && (t >= fall_at + LAT));
         chk("hs_req", 32'(REQ), 32'(exp_req));
         chk("hs_tx_done", 32'(TX_DONE), 32'(exp_done));
         chk("hs_ready", 32'(READY), 32'(exp_ready));
         chk("hs_data_stable", 32'(DATA_OUT), 32'(w));
         if (fall_at >= 0 && t == fall_at + LAT) fin = 1'b1;
         if (rise_at < 0 && ACK_ASYNC === 1'b1) rise_at = t;
         else if (rise_at >= 0 && fall_at < 0 && ACK_ASYNC === 1'b0) fall_at = t;
      end
      chk("hs_complete", 32'(fin), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] w, nxt;
      bit            hold;
      int            k, d0;

      RST        = 1'b0;
      DATA_IN    = '0;
      DATA_VALID = 1'b0;
      ACK_ASYNC  = 1'b0;
      ack_auto   = 1'b1;
      ack_man    = 1'b0;
      req_sh     = '0;

      // Reset asserted mid-cycle clears outputs immediately; READY rises one edge after release.
      #7 RST = 1'b1;
      #1;
      chk("rst_req", 32'(REQ), 32'(0));
      chk("rst_data_out", 32'(DATA_OUT), 32'(0));
      chk("rst_ready", 32'(READY), 32'(0));
      chk("rst_tx_done", 32'(TX_DONE), 32'(0));
      repeat (3) tick();
      RST = 1'b0;
      chk("ready_before_first_edge", 32'(READY), 32'(0));
      tick();
      chk("ready_after_release", 32'(READY), 32'(1));

      // Single word.
      launch(8'hA5);
      handshake(8'hA5, 1'b0, 8'h00);

`ifndef CDC_TX_SKID_EN
      // A word held valid during a handshake is ignored until READY returns, then taken at once.
      launch(8'hA5);
      handshake(8'hA5, 1'b1, 8'h3C);
      launch(8'h3C);
      handshake(8'h3C, 1'b0, 8'h00);
`endif

      // Reset in the middle of a handshake: REQ drops at once, the word is lost, no TX_DONE.
      wait_ready("ready_before_abort");
      launch(8'h55);
      tick();
      tick();
      #2 RST = 1'b1;
      #1;
      chk("abort_req", 32'(REQ), 32'(0));
      chk("abort_data_out", 32'(DATA_OUT), 32'(0));
      chk("abort_tx_done", 32'(TX_DONE), 32'(0));
      sent_q.delete();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_no_done", 32'(TX_DONE), 32'(0));
      end
      RST = 1'b0;
      wait_ready("ready_after_abort");
      launch(8'h11);
      handshake(8'h11, 1'b0, 8'h00);

`ifndef CDC_TX_SKID_EN
      // Ack held high across reset release. The chain restarts cleared, so the held level
      // only reaches the control logic once it has filled; from then on READY must stay low.
      ack_auto  = 1'b0;
      ack_man   = 1'b1;
      ACK_ASYNC = 1'b1;
      #2 RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      repeat (LAT) tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stale_ack_ready", 32'(READY), 32'(0));
      end
      DATA_IN    = 8'h77;
      DATA_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stale_ack_no_req", 32'(REQ), 32'(0));
      end
      DATA_VALID = 1'b0;
      ack_man    = 1'b0;
      ACK_ASYNC  = 1'b0;
      for (int i = 1; i <= LAT; i++) begin
         tick();
         chk("ack_low_ready", 32'(READY), 32'(i == LAT));
      end
      ack_auto = 1'b1;
`endif

`ifdef CDC_TX_SKID_EN
      // Back-to-back words: first launches, second parks, third waits until the second launches.
      wait_ready("skid_ready");
      d0         = done_cnt;
      DATA_IN    = 8'h11;
      DATA_VALID = 1'b1;
      sent_q.push_back(8'h11);
      tick();
      chk("skid_launch11", 32'(DATA_OUT), 32'(8'h11));
      chk("skid_req11", 32'(REQ), 32'(1));
      chk("skid_ready_after11", 32'(READY), 32'(1));
      DATA_IN = 8'h22;
      sent_q.push_back(8'h22);
      tick();
      chk("skid_full", 32'(READY), 32'(0));
      chk("skid_still11", 32'(DATA_OUT), 32'(8'h11));
      DATA_IN = 8'h33;
      k = 0;
      while (DATA_OUT !== 8'h22 && k < 40) begin
         tick();
         k++;
         if (DATA_OUT !== 8'h22) chk("skid_hold33", 32'(READY), 32'(0));
      end
      chk("skid_launch22", 32'(DATA_OUT), 32'(8'h22));
      chk("skid_req22", 32'(REQ), 32'(1));
      chk("skid_ready_freed", 32'(READY), 32'(1));
      sent_q.push_back(8'h33);
      tick();
      DATA_VALID = 1'b0;
      chk("skid_33_parked", 32'(READY), 32'(0));
      k = 0;
      while (done_cnt < d0 + 3 && k < 200) begin
         tick();
         k++;
      end
      chk("skid_three_done", 32'(done_cnt - d0), 32'(3));
      chk("skid_last_word", 32'(DATA_OUT), 32'(8'h33));
      chk("skid_queue_drained", 32'(sent_q.size()), 32'(0));
      wait_ready("skid_ready_end");
      repeat (8) tick();
`endif

      // Randomized words, gaps and (without skid) held-valid words during busy periods.
      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 3)) tick();
         wait_ready("rnd_ready");
         w    = DW'($urandom);
         nxt  = DW'($urandom);
         hold = SKID ? 1'b0 : 1'($urandom_range(0, 1));
         launch(w);
         handshake(w, hold, nxt);
         if (hold) begin
            launch(nxt);
            handshake(nxt, 1'b0, 8'h00);
         end
      end
      chk("final_queue_empty", 32'(sent_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
